// File: rtl/volley_sequencer.sv
// Sequences one spiking layer through its time window: buffers the next volley,
// drives time_val, captures the layer output and returns it over valid/ready.
module volley_sequencer #(
  parameter int TIME_PERIOD = 8,
  parameter int NUM_SPIKES  = 16,
  parameter int TBITS       = $clog2(TIME_PERIOD) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_SPIKES*TBITS-1:0] in_spike_times,
  input  logic                        pause,
  output logic [TBITS-1:0]            layer_time_val,
  output logic [NUM_SPIKES*TBITS-1:0] layer_spike_times,
  input  logic [TBITS-1:0]            layer_out_spike_time,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [TBITS-1:0]            out_spike_time,
  output logic                        busy,
  output logic [15:0]                 volley_count
);

  localparam logic [TBITS-1:0] TIME_IDLE = TBITS'(TIME_PERIOD);
  localparam logic [TBITS-1:0] TIME_LAST = TBITS'(TIME_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, RUN, CAPTURE} state_t;

  state_t                        state_reg, state_next;
  logic [NUM_SPIKES*TBITS-1:0]   buf_reg;
  logic                          buf_full_reg, buf_full_next;
  logic [NUM_SPIKES*TBITS-1:0]   active_reg;
  logic [TBITS-1:0]              time_reg, time_next;
  logic                          out_valid_reg, out_valid_next;
  logic [TBITS-1:0]              out_reg;
  logic [15:0]                   count_reg, count_next;
  logic                          accept;
  logic                          load_active;
  logic                          capture;

  assign accept = in_valid && !buf_full_reg;

  always_comb begin
    state_next  = state_reg;
    time_next   = time_reg;
    load_active = 1'b0;
    capture     = 1'b0;
    case (state_reg)
      IDLE: begin
        time_next = TIME_IDLE;
        if (buf_full_reg) begin
          state_next  = RUN;
          load_active = 1'b1;
          time_next   = '0;
        end
      end
      RUN: begin
        if (!pause) begin
          if (time_reg == TIME_LAST) begin
            state_next = CAPTURE;
            time_next  = TIME_IDLE;
          end else begin
            time_next = time_reg + 1'b1;
          end
        end
      end
      CAPTURE: begin
        // time_val parked at TIME_PERIOD keeps the layer output frozen while stalled
        time_next = TIME_IDLE;
        if (!out_valid_reg || out_ready) begin
          capture = 1'b1;
          if (buf_full_reg) begin
            state_next  = RUN;
            load_active = 1'b1;
            time_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        time_next  = TIME_IDLE;
      end
    endcase

    buf_full_next = buf_full_reg;
    if (accept)
      buf_full_next = 1'b1;
    else if (load_active)
      buf_full_next = 1'b0;

    // a capture on the drain edge keeps out_valid high with the new value
    out_valid_next = out_valid_reg;
    if (capture)
      out_valid_next = 1'b1;
    else if (out_valid_reg && out_ready)
      out_valid_next = 1'b0;

    count_next = capture ? count_reg + 16'd1 : count_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      buf_reg       <= '0;
      buf_full_reg  <= 1'b0;
      active_reg    <= '0;
      time_reg      <= TIME_IDLE;
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
      count_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      buf_full_reg  <= buf_full_next;
      time_reg      <= time_next;
      out_valid_reg <= out_valid_next;
      count_reg     <= count_next;
      if (accept)
        buf_reg <= in_spike_times;
      if (load_active)
        active_reg <= buf_reg;
      if (capture)
        out_reg <= layer_out_spike_time;
    end
  end

  assign in_ready          = !buf_full_reg;
  assign layer_time_val    = time_reg;
  assign layer_spike_times = active_reg;
  assign out_valid         = out_valid_reg;
  assign out_spike_time    = out_reg;
  assign volley_count      = count_reg;
  assign busy              = (state_reg != IDLE) || buf_full_reg || out_valid_reg;

endmodule

// File: tb/tb_volley_sequencer.sv
// Directed bench for volley_sequencer: expected results are queued at issue time
// and a negedge monitor pops and compares them as the DUT hands results out.
module tb_volley_sequencer;

  localparam int TP = 8;
  localparam int NS = 16;
  localparam int TB = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [NS*TB-1:0] in_spike_times = '0;
  logic             pause = 1'b0;
  logic [TB-1:0]    layer_time_val;
  logic [NS*TB-1:0] layer_spike_times;
  logic [TB-1:0]    layer_out_spike_time = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [TB-1:0]    out_spike_time;
  logic             busy;
  logic [15:0]      volley_count;

  int checks = 0;
  int errors = 0;
  logic [TB-1:0] sb[$];

  volley_sequencer #(.TIME_PERIOD(TP), .NUM_SPIKES(NS), .TBITS(TB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_spike_times(in_spike_times),
    .pause(pause), .layer_time_val(layer_time_val), .layer_spike_times(layer_spike_times),
    .layer_out_spike_time(layer_out_spike_time),
    .out_valid(out_valid), .out_ready(out_ready), .out_spike_time(out_spike_time),
    .busy(busy), .volley_count(volley_count)
  );

  always #5 clk = ~clk;

  // Stand-in layer: registers entry 0 of the active volley on the last window edge.
  always @(posedge clk)
    if (layer_time_val == TB'(TP - 1))
      layer_out_spike_time <= layer_spike_times[TB-1:0];

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected got=%0h required=none", out_spike_time);
      end else begin
        logic [TB-1:0] exp_v;
        exp_v = sb.pop_front();
        if (out_spike_time !== exp_v) begin
          errors++;
          $display("FAIL result got=%0h required=%0h", out_spike_time, exp_v);
        end else begin
          $display("result ok %0h", out_spike_time);
        end
      end
    end
  end

  function automatic logic [NS*TB-1:0] pattern(input logic [TB-1:0] v);
    logic [NS*TB-1:0] p;
    for (int i = 0; i < NS; i++) p[i*TB +: TB] = v + TB'(i);
    return p;
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, act, req);
    end else begin
      $display("check %s = %0h", name, act);
    end
  endtask

  // Holds the volley on the input until the edge where it is accepted.
  task automatic offer(input logic [TB-1:0] v);
    logic rdy;
    int   n;
    in_valid       = 1'b1;
    in_spike_times = pattern(v);
    sb.push_back(v);
    n = 0;
    do begin
      rdy = in_ready;
      step(1);
      n++;
    end while (!rdy && n < 50);
    in_valid = 1'b0;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout volley=%0h got=not_accepted required=accepted", v);
    end
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    check("reset_time_val", layer_time_val, 64'(TP));
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_count", volley_count, 0);
    check("reset_busy", busy, 0);
    check("reset_layer_spikes", layer_spike_times, 0);
    check("reset_out_time", out_spike_time, 0);

    // single volley, latency
    offer(4'h3);
    check("t1_buf_full", in_ready, 0);
    for (int k = 0; k < TP; k++) begin
      step(1);
      check($sformatf("t1_time_%0d", k), layer_time_val, 64'(k));
      check("t1_in_ready", in_ready, 1);
      if (k == 0) check("t1_layer_spikes", layer_spike_times, pattern(4'h3));
    end
    step(1);
    check("t1_capture_time", layer_time_val, 64'(TP));
    check("t1_no_valid_yet", out_valid, 0);
    step(1);
    check("t1_out_valid", out_valid, 1);
    check("t1_count", volley_count, 1);
    step(1);
    check("t1_drained", out_valid, 0);
    check("t1_idle_busy", busy, 0);

    // back-to-back volleys
    offer(4'h5);
    offer(4'h6);
    step(8);
    check("t2_second_run_time", layer_time_val, 0);
    check("t2_first_valid", out_valid, 1);
    check("t2_second_spikes", layer_spike_times, pattern(4'h6));
    check("t2_count_a", volley_count, 2);
    step(8);
    check("t2_capture_time", layer_time_val, 64'(TP));
    check("t2_gap_valid", out_valid, 0);
    step(1);
    check("t2_second_valid", out_valid, 1);
    check("t2_count_b", volley_count, 3);
    step(1);

    // output stall across two windows
    out_ready = 1'b0;
    offer(4'h7);
    offer(4'h8);
    offer(4'h9);
    step(9);
    check("t3_stall_time", layer_time_val, 64'(TP));
    check("t3_stall_in_ready", in_ready, 0);
    check("t3_held_valid", out_valid, 1);
    check("t3_held_value", out_spike_time, 4'h7);
    check("t3_stall_busy", busy, 1);
    check("t3_stall_count", volley_count, 4);
    out_ready = 1'b1;
    step(1);
    check("t3_swap_valid", out_valid, 1);
    check("t3_swap_value", out_spike_time, 4'h8);
    check("t3_third_run", layer_time_val, 0);
    check("t3_swap_count", volley_count, 5);
    check("t3_in_ready", in_ready, 1);
    step(9);
    check("t3_third_valid", out_valid, 1);
    check("t3_third_count", volley_count, 6);
    step(1);

    // pause holds time_val and delays the result by the pause length
    offer(4'h4);
    step(5);
    check("t4_time_before_pause", layer_time_val, 4);
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1);
      check("t4_paused_time", layer_time_val, 4);
    end
    pause = 1'b0;
    step(1);
    check("t4_resumed_time", layer_time_val, 5);
    step(3);
    check("t4_late_capture_time", layer_time_val, 64'(TP));
    check("t4_not_yet_valid", out_valid, 0);
    step(1);
    check("t4_delayed_valid", out_valid, 1);
    check("t4_count", volley_count, 7);
    step(2);

    // reset mid-window with the buffer full discards everything
    offer(4'hA);
    offer(4'hB);
    step(4);
    check("t5_time_before_rst", layer_time_val, 5);
    check("t5_buf_full", in_ready, 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    sb.delete();
    check("t5_rst_time", layer_time_val, 64'(TP));
    check("t5_rst_in_ready", in_ready, 1);
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_count", volley_count, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_layer_spikes", layer_spike_times, 0);
    step(15);
    check("t5_no_result", out_valid, 0);
    check("t5_still_idle", layer_time_val, 64'(TP));

    // volley_count wrap
    force dut.count_reg = 16'hFFFF;
    step(1);
    release dut.count_reg;
    step(1);
    check("t6_preload", volley_count, 16'hFFFF);
    offer(4'hC);
    step(10);
    check("t6_wrap_valid", out_valid, 1);
    check("t6_wrap_count", volley_count, 0);
    step(2);

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
